data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the 64-bit processor data port. It accepts one load or store request at a time over a valid/ready handshake and models a fixed access latency of `LATENCY` cycles. It returns each result over a second valid/ready handshake, sitting between the datapath's `aluout`/`writedata` load-store path and a word-addressed storage array. It replaces the zero-latency data memory once the core moves to stall-capable memory access.

## Interface
- `DEPTH`, 256, number of 64-bit words; power of two, ≥ 2
- `LATENCY`, 2, cycles from request acceptance to response; ≥ 1
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  64  byte address
- `req_wdata`  in  64  store data
- `req_be`  in  8  store byte enables; bit i enables byte i (bits 8i+7:8i)
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer takes the response
- `resp_rdata`  out  64  load data; 0 for stores and errors
- `resp_err`  out  1  request was misaligned

## Operation
- **States:**
  - IDLE: `req_ready` is 1.
  - BUSY: a down-counter runs.
  - RESP: `resp_valid` is 1.
- **IDLE:** on `req_valid && req_ready` at an edge, capture `we`, `addr`, `wdata` and `be`. Load the counter with `LATENCY-1` and go to BUSY.
- **BUSY:** if the counter is 0, go to RESP at the edge. Otherwise decrement it.
- **BUSY→RESP edge (commit):**
  - word index = `addr[3 +: log2(DEPTH)]`. Upper address bits are ignored, so accesses wrap modulo `DEPTH`.
  - misaligned (`addr[2:0] != 0`): `resp_err` = 1, `resp_rdata` = 0, and no storage write.
  - aligned store: write only the bytes enabled in `be`. `resp_rdata` = 0, `resp_err` = 0.
  - aligned load: `resp_rdata` = the stored word, `resp_err` = 0.
- **RESP:** hold `resp_valid`, `resp_rdata` and `resp_err` stable until `resp_ready` is 1 at an edge, then go to IDLE.
- A new request is never accepted in the same edge as a response handshake.
- `req_ready` = (state == IDLE) && !`reset`. It is registered-state derived with no combinational path from `req_valid`.
- **Reset:**
  - the state goes to IDLE and the counter to 0.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - an in-flight store that has not yet committed is dropped.
  - storage contents are not reset and are undefined at power-up.
- `req_*` inputs outside an accepting edge are don't-care.
- `resp_ready` outside RESP is don't-care.

## Timing
- Request accepted at edge E0 → `resp_valid` high immediately after edge E(`LATENCY`).
- Minimum transaction period is `LATENCY`+1 cycles when `resp_ready` is held at 1; it is `LATENCY`+2 if you count the IDLE cycle before acceptance.
- A store committed at edge Ek is visible to any load accepted at or after edge Ek+1.
- `resp_rdata`/`resp_err` change only at the commit edge or at reset.
- Reset assertion takes effect without a clock edge. The first acceptance can occur at the first edge after deassertion.

## Structure
- Shared package `dmem_pkg` holds:
  - the state encoding (IDLE, BUSY, RESP)
  - `WORD_W` = 64
  - `BE_W` = 8
  - the alignment mask constant 3'b111
- Sub-module `dmem_array`:
  - synchronous byte-enabled write with a registered read, used only at the commit edge
  - parameter `DEPTH`
  - ports `clk`, `we`, `be`, `idx`, `wdata`, `rdata`
- Top level contains the FSM, the latency counter, the request capture registers and the response registers.

## Test plan
- Store 64'h1122334455667788 to 0x40 with `be`=8'hFF, then load 0x40. Required: `resp_rdata`=64'h1122334455667788, `resp_err`=0. `resp_valid` rises exactly `LATENCY` edges after each acceptance.
- Store 64'hFFFF_FFFF_FFFF_FFFF to 0x40 with `be`=8'h0F, then load 0x40. Required: 64'h11223344FFFFFFFF.
- Load 0x43. Required: `resp_err`=1, `resp_rdata`=0. Then store to 0x45 and load 0x40. Required: the word is unchanged.
- With `DEPTH`=256, store 64'hA5 to 0x800 and load 0x0. Required: 64'hA5 (wrap-around).
- Hold `resp_ready`=0 for 5 cycles in RESP. Required: `resp_valid`, `resp_rdata` and `resp_err` are stable and `req_ready`=0. Raising `resp_ready` returns the block to IDLE on the next edge.
- Accept a store to 0x80, then assert `reset` mid-BUSY. Required: `resp_valid`=0 asynchronously, and no response appears. After a prior store of 64'h5 to 0x80, a later load of 0x80 returns the old value 64'h5.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: word geometry, FSM
// encoding and the byte-alignment helper.
package dmem_pkg;

  localparam int WORD_W = 64;
  localparam int BE_W   = 8;
  localparam int ADDR_W = 64;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 3'b000;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the load-store path (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word-addressed storage with byte-enabled synchronous write and a
// registered read port. Contents are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [BE_W-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] rdata_r;

  // byte-lane write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata_r <= mem_r[idx];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory-side responder: accepts one load/store, waits LATENCY
// cycles, commits to the array and holds the response until it is taken.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ADDR_LO = IDX_W + 3;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 we_r;
  logic [ADDR_LO-1:0]   addr_r;
  logic [WORD_W-1:0]    wdata_r;
  logic [BE_W-1:0]      be_r;
  logic                 resp_valid_r;
  logic [WORD_W-1:0]    resp_rdata_r;
  logic                 resp_err_r;
  logic                 req_ready_s;
  logic                 accept_s;
  logic                 commit_s;
  logic                 misaligned_s;
  logic                 arr_we_s;
  logic [IDX_W-1:0]     idx_s;
  logic [WORD_W-1:0]    arr_rdata_s;
  logic                 unused_addr_s;

  assign req_ready_s  = (state_r == ST_IDLE) && !reset;
  assign accept_s     = bus.req_valid && req_ready_s;
  assign commit_s     = (state_r == ST_BUSY) && (cnt_r == '0);
  assign misaligned_s = is_misaligned(addr_r[2:0]);
  assign arr_we_s     = commit_s && we_r && !misaligned_s;
  // Read port tracks the incoming address while idle so the word is ready
  // even when the commit edge directly follows acceptance.
  assign idx_s        = (state_r == ST_IDLE) ? bus.req_addr[3 +: IDX_W] : addr_r[3 +: IDX_W];
  assign unused_addr_s = ^bus.req_addr[ADDR_W-1:ADDR_LO];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s)           state_nxt_s = ST_BUSY; else state_nxt_s = ST_IDLE;
      ST_BUSY: if (cnt_r == '0)        state_nxt_s = ST_RESP; else state_nxt_s = ST_BUSY;
      ST_RESP: if (bus.resp_ready)     state_nxt_s = ST_IDLE; else state_nxt_s = ST_RESP;
      default:                         state_nxt_s = ST_IDLE;
    endcase
  end

  // latency down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cnt_r <= '0;
    else if (accept_s)                          cnt_r <= CNT_W'(LATENCY - 1);
    else if (state_r == ST_BUSY && cnt_r != '0) cnt_r <= cnt_r - CNT_W'(1);
    else                                        cnt_r <= cnt_r;
  end

  // request capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= '0;
    end else if (accept_s) begin
      we_r    <= bus.req_we;
      addr_r  <= bus.req_addr[ADDR_LO-1:0];
      wdata_r <= bus.req_wdata;
      be_r    <= bus.req_be;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      be_r    <= be_r;
    end
  end

  // response registers; data/err only move at commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
    end else if (commit_s) begin
      resp_valid_r <= 1'b1;
      resp_err_r   <= misaligned_s;
      resp_rdata_r <= (misaligned_s || we_r) ? {WORD_W{1'b0}} : arr_rdata_s;
    end else if (state_r == ST_RESP && bus.resp_ready) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .be    (be_r),
    .idx   (idx_s),
    .wdata (wdata_r),
    .rdata (arr_rdata_s)
  );

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [63:0] model_mem [DEPTH];

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; checks latency, response and RESP-state stability.
  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] be, input int hold);
    int          waited;
    int          edges;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          idx;
    @(negedge clk);
    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_val("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_be     = be;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = {$urandom, $urandom};
    edges = 0;
    while (!bus.resp_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_val("latency", 64'(edges), 64'(LATENCY));

    idx     = int'((addr / 64'd8) % 64'(DEPTH));
    exp_err = (addr % 64'd8) != 64'd0;
    exp_rdata = 64'd0;
    if (!exp_err && !we) exp_rdata = model_mem[idx];
    if (!exp_err && we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    check_val("resp_rdata", bus.resp_rdata, exp_rdata);
    check_val("resp_err", 64'(bus.resp_err), 64'(exp_err));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", 64'(bus.resp_valid), 64'd1);
      check_val("hold_rdata", bus.resp_rdata, exp_rdata);
      check_val("hold_err", 64'(bus.resp_err), 64'(exp_err));
      check_val("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check_val("resp_done_valid", 64'(bus.resp_valid), 64'd0);
    check_val("resp_done_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    bus.req_be     = 8'd0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(bus.resp_valid), 64'd0);
    check_val("rst_rdata", bus.resp_rdata, 64'd0);
    check_val("rst_err", 64'(bus.resp_err), 64'd0);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("post_rst_ready", 64'(bus.req_ready), 64'd1);

    // Give every word a known value so the model is fully defined.
    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b1, 64'(i) * 64'd8, {$urandom, $urandom}, 8'hFF, 0);
    end

    txn(1'b1, 64'h40, 64'h1122334455667788, 8'hFF, 0);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 0);
    check_val("dir_full_store", model_mem[8], 64'h1122334455667788);
    txn(1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 0);
    check_val("dir_partial_store", model_mem[8], 64'h11223344FFFFFFFF);
    txn(1'b0, 64'h43, 64'd0, 8'h00, 0);
    txn(1'b1, 64'h45, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 0);
    txn(1'b1, 64'h800, 64'hA5, 8'hFF, 0);
    txn(1'b0, 64'h0, 64'd0, 8'h00, 0);
    check_val("dir_wrap", model_mem[0], 64'hA5);
    txn(1'b0, 64'h40, 64'd0, 8'h00, 5);

    // Reset during BUSY drops the store.
    txn(1'b1, 64'h80, 64'h5, 8'hFF, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 64'h80;
    bus.req_wdata = 64'hDEAD_0000_BEEF_0000;
    bus.req_be    = 8'hFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
    check_val("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < LATENCY + 3; c++) begin
      @(posedge clk);
      #1;
      check_val("no_resp_after_rst", 64'(bus.resp_valid), 64'd0);
    end
    txn(1'b0, 64'h80, 64'd0, 8'h00, 0);
    check_val("dropped_store", model_mem[16], 64'h5);

    // Random mix of loads/stores, misalignments, wrapped addresses and stalls.
    for (int n = 0; n < 300; n++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(7) != 0) a[2:0] = 3'b000;
      txn(1'($urandom_range(1)), a, {$urandom, $urandom}, 8'($urandom), $urandom_range(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
